// File: rtl/router_pkg.sv
// Shared types and constants for the 4-port router arbiter.
// Holds port count/width, FSM encoding and a one-hot helper.
package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [NUM_PORTS-1:0] onehot(
        input logic [PORT_W-1:0] idx
    );
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports: req (request levels), last_granted (previous winner),
//        valid (any request), index (winner).
module rr_picker
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_granted,
    output logic                 valid,
    output logic [PORT_W-1:0]    index
);

    logic [PORT_W-1:0] cand;

    // Walk candidates from the farthest to the nearest so that the
    // last hit written is the first asserted one after last_granted.
    always_comb begin
        valid = 1'b0;
        index = last_granted;
        cand  = last_granted;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = last_granted + PORT_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/router_arbiter.sv
// Round-robin burst arbiter driving router sender/receiver selects.
// Ports: clk, rst_n, req[4], dest0..dest3[2]; out grant[4] one-hot,
//        sender[2], receiver[2], route_en (all registered).
module router_arbiter
    import router_pkg::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    dest0,
    input  logic [PORT_W-1:0]    dest1,
    input  logic [PORT_W-1:0]    dest2,
    input  logic [PORT_W-1:0]    dest3,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PORT_W-1:0]    sender,
    output logic [PORT_W-1:0]    receiver,
    output logic                 route_en
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t               state, state_n;
    logic [NUM_PORTS-1:0] grant_n;
    logic [PORT_W-1:0]    sender_n, receiver_n;
    logic [PORT_W-1:0]    last_granted, last_n;
    logic                 route_en_n;
    logic [3:0]           cnt, cnt_n;
    logic [PORT_W-1:0]    dest [NUM_PORTS];
    logic                 pick_valid;
    logic [PORT_W-1:0]    pick_idx;

    assign dest[0] = dest0;
    assign dest[1] = dest1;
    assign dest[2] = dest2;
    assign dest[3] = dest3;

    rr_picker u_pick (
        .req          (req),
        .last_granted (last_granted),
        .valid        (pick_valid),
        .index        (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            sender       <= '0;
            receiver     <= '0;
            route_en     <= 1'b0;
            cnt          <= '0;
            last_granted <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            sender       <= sender_n;
            receiver     <= receiver_n;
            route_en     <= route_en_n;
            cnt          <= cnt_n;
            last_granted <= last_n;
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        sender_n   = sender;
        receiver_n = receiver;
        route_en_n = route_en;
        cnt_n      = cnt;
        last_n     = last_granted;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n    = XFER;
                    grant_n    = onehot(pick_idx);
                    sender_n   = pick_idx;
                    receiver_n = dest[pick_idx];
                    route_en_n = 1'b1;
                    cnt_n      = '0;
                    last_n     = pick_idx;
                end
            end
            XFER: begin
                cnt_n = cnt + 4'd1;
                // Burst limit and requester drop share one exit path,
                // so a coincident pair still ends the burst once.
                if (cnt == LAST_BEAT || !req[sender]) begin
                    state_n    = GAP;
                    grant_n    = '0;
                    route_en_n = 1'b0;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n    = IDLE;
                grant_n    = '0;
                route_en_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_arbiter.sv
// Self-checking bench for router_arbiter (BURST_LEN 8 and 1).
// Directed scenarios plus random traffic against a reference model.
module tb_router_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] dest0, dest1, dest2, dest3;

    logic [3:0] grant8, grant1;
    logic [1:0] sender8, sender1, receiver8, receiver1;
    logic       route_en8, route_en1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    router_arbiter #(.BURST_LEN(8)) u8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .dest0    (dest0),
        .dest1    (dest1),
        .dest2    (dest2),
        .dest3    (dest3),
        .grant    (grant8),
        .sender   (sender8),
        .receiver (receiver8),
        .route_en (route_en8)
    );

    router_arbiter #(.BURST_LEN(1)) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .dest0    (dest0),
        .dest1    (dest1),
        .dest2    (dest2),
        .dest3    (dest3),
        .grant    (grant1),
        .sender   (sender1),
        .receiver (receiver1),
        .route_en (route_en1)
    );

    // Reference model: per instance, who owns the link (-1 none),
    // beats delivered so far, whether the gap cycle is running.
    int blen   [2] = '{8, 1};
    int owner  [2];
    int beats  [2];
    int last   [2];
    int snd    [2];
    int rcv    [2];
    bit in_gap [2];

    function automatic int dest_of(int i);
        case (i)
            0:       return int'(dest0);
            1:       return int'(dest1);
            2:       return int'(dest2);
            default: return int'(dest3);
        endcase
    endfunction

    function automatic logic [3:0] g(int sel);
        return (sel == 0) ? grant8 : grant1;
    endfunction

    function automatic logic ren(int sel);
        return (sel == 0) ? route_en8 : route_en1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i]  = -1;
            beats[i]  = 0;
            in_gap[i] = 1'b0;
            last[i]   = 3;
            snd[i]    = 0;
            rcv[i]    = 0;
        end
    endtask

    task automatic model_edge();
        int pick;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                owner[i]  = -1;
                beats[i]  = 0;
                in_gap[i] = 1'b0;
                last[i]   = 3;
                snd[i]    = 0;
                rcv[i]    = 0;
            end else if (owner[i] >= 0) begin
                if (beats[i] == blen[i] || !req[owner[i]]) begin
                    owner[i]  = -1;
                    in_gap[i] = 1'b1;
                end else begin
                    beats[i]++;
                end
            end else if (in_gap[i]) begin
                in_gap[i] = 1'b0;
            end else if (req != 4'b0) begin
                pick = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (pick < 0 && req[(last[i] + k) % 4])
                        pick = (last[i] + k) % 4;
                end
                owner[i] = pick;
                last[i]  = pick;
                beats[i] = 1;
                snd[i]   = pick;
                rcv[i]   = dest_of(pick);
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        logic [31:0] eg;
        for (int i = 0; i < 2; i++) begin
            eg = (owner[i] >= 0) ? (32'd1 << owner[i]) : 32'd0;
            chk($sformatf("grant_b%0d", blen[i]),
                32'(i == 0 ? grant8 : grant1), eg);
            chk($sformatf("route_en_b%0d", blen[i]),
                32'(i == 0 ? route_en8 : route_en1),
                32'(owner[i] >= 0));
            chk($sformatf("sender_b%0d", blen[i]),
                32'(i == 0 ? sender8 : sender1), 32'(snd[i]));
            chk($sformatf("receiver_b%0d", blen[i]),
                32'(i == 0 ? receiver8 : receiver1), 32'(rcv[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant8", 32'(grant8), 32'd0);
        chk("rst_ren8", 32'(route_en8), 32'd0);
        chk("rst_sender8", 32'(sender8), 32'd0);
        chk("rst_recv8", 32'(receiver8), 32'd0);
        chk("rst_grant1", 32'(grant1), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(string tag, int sel, int idx);
        int n;
        n = 0;
        while (g(sel) == 4'b0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(g(sel)), 32'd1 << idx);
    endtask

    task automatic count_beats(int sel, output int n);
        n = 0;
        while (ren(sel) && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int tot;
        rst_n = 1'b0;
        req   = 4'b0;
        dest0 = 2'd0;
        dest1 = 2'd0;
        dest2 = 2'd0;
        dest3 = 2'd0;
        model_reset();
        tick();
        do_reset();

        // single requester, full burst, re-grant after gap
        req   = 4'b0001;
        dest0 = 2'd3;
        wait_grant("r30_grant", 0, 0);
        chk("r30_recv", 32'(receiver8), 32'd3);
        count_beats(0, n);
        chk("r30_beats", 32'(n), 32'd8);
        chk("r30_gap", 32'(grant8), 32'd0);
        wait_grant("r30_regrant", 0, 0);

        // all requesting: rotation 0,1,2,3,0
        do_reset();
        req   = 4'b1111;
        dest0 = 2'd1;
        dest1 = 2'd2;
        dest2 = 2'd3;
        dest3 = 2'd0;
        for (int j = 0; j < 5; j++) begin
            wait_grant($sformatf("r31_grant%0d", j), 0, j % 4);
            chk("r31_recv", 32'(receiver8), 32'(dest_of(j % 4)));
            count_beats(0, n);
            chk("r31_beats", 32'(n), 32'd8);
        end

        // requester drops after its third beat
        do_reset();
        req = 4'b0100;
        wait_grant("r32_grant", 0, 2);
        tick();
        tick();
        req = 4'b0000;
        count_beats(0, n);
        tot = 2 + n;
        chk("r32_beats", 32'(tot), 32'd3);

        // destination change and competing request mid-transfer
        do_reset();
        req   = 4'b0010;
        dest1 = 2'd2;
        wait_grant("r33_grant", 0, 1);
        tick();
        dest1 = 2'd0;
        req   = 4'b1010;
        tick();
        tick();
        chk("r33_recv_hold", 32'(receiver8), 32'd2);
        count_beats(0, n);
        wait_grant("r33_next", 0, 3);

        // reset at beat 5, then fresh arbitration
        do_reset();
        req = 4'b0001;
        wait_grant("r34_grant", 0, 0);
        for (int j = 0; j < 4; j++) tick();
        chk("r34_beat5", 32'(route_en8), 32'd1);
        req = 4'b0110;
        do_reset();
        wait_grant("r34_after", 0, 1);

        // single-beat bursts alternating 0,2
        do_reset();
        req = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            wait_grant($sformatf("r35_grant%0d", j), 1, (j % 2) * 2);
            count_beats(1, n);
            chk("r35_beats", 32'(n), 32'd1);
        end

        // random traffic
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 4) == 0) begin
                dest0 = 2'($urandom_range(0, 3));
                dest1 = 2'($urandom_range(0, 3));
                dest2 = 2'($urandom_range(0, 3));
                dest3 = 2'($urandom_range(0, 3));
            end
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_arbiter.md
ROUTER_ARBITER -- requirements
Module: router_arbiter

Interface
REQ-001 Parameter: BURST_LEN, 8, maximum beats per grant; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  req[i] = requester i wants a transfer; level, held until done.
REQ-005 dest0, dest1, dest2, dest3  input  2 each  requested receiver index of requester i.
REQ-006 grant  output  4  one-hot granted requester; all-zero when no transfer.
REQ-007 sender  output  2  index of granted requester; drives the router sender select.
REQ-008 receiver  output  2  latched destination of granted requester; drives the router receiver select.
REQ-009 route_en  output  1  high while a transfer beat is active; downstream qualifies data with it.

Function
REQ-010 FSM states SHALL be IDLE, XFER and GAP, all outputs registered.
REQ-011 IDLE: if req != 0 at an edge, the arbiter SHALL pick a requester round-robin, enter XFER, and present grant/sender/receiver/route_en after that same edge (1-cycle latency from sampled req).
REQ-012 Round-robin order SHALL start at (last_granted+1) mod 4 and take the first asserted req in ascending wrap-around order.
REQ-013 last_granted SHALL update only when a grant is issued.
REQ-014 receiver SHALL be captured from dest of the winner at grant and held constant for the whole transfer; dest changes mid-transfer ignored.
REQ-015 A 4-bit beat counter SHALL clear at grant and increment each XFER cycle.
REQ-016 XFER SHALL end, entering GAP, at the edge where counter == BURST_LEN-1 or req[sender] is sampled low, whichever first.
REQ-017 If req[sender] drops, the transfer SHALL end at that edge; route_en low from the next cycle, no extra beat.
REQ-018 Simultaneous last beat and req[sender] drop SHALL produce a single termination, identical timing.
REQ-019 With BURST_LEN = 1 each grant SHALL last exactly one route_en cycle.
REQ-020 GAP SHALL last exactly one cycle with grant=0, route_en=0, sender/receiver holding last values, then go to IDLE.
REQ-021 A requester still asserting req after its burst SHALL be re-eligible, but SHALL lose to any other asserted requester.
REQ-022 Requests from non-granted requesters SHALL never alter an ongoing transfer.
REQ-023 grant SHALL be one-hot or zero in every cycle; route_en == |grant.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, grant=0, sender=0, receiver=0, route_en=0, counter=0, last_granted=3 (so requester 0 has first priority).
REQ-025 Reset asserted mid-transfer SHALL abort it with no further beats; after deassertion arbitration restarts from IDLE.
REQ-026 Reset deassertion SHALL be taken as synchronous to clk by the surrounding system; no internal synchronizer.

Structure
REQ-027 Shared package router_pkg SHALL hold NUM_PORTS=4, PORT_W=2, and state encodings IDLE/XFER/GAP.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req, last_granted; outputs valid, index).
REQ-029 sender/receiver SHALL connect directly to the downstream router select ports without further logic.

Verification
REQ-030 Reset, then req=4'b0001, dest0=3 held -> grant=0001, sender=0, receiver=3, route_en high exactly 8 cycles, 1 GAP cycle, next grant to 0 again.
REQ-031 req=4'b1111 held, dests 1,2,3,0 -> grants in order 0,1,2,3,0, each 8 beats separated by one GAP cycle; receiver matches dest.
REQ-032 Grant to requester 2, drop req[2] after beat 3 -> route_en for exactly 3 cycles, then GAP.
REQ-033 During transfer to 1 (dest1=2), change dest1 to 0 and assert req[3] -> receiver stays 2; requester 3 granted after GAP.
REQ-034 Assert rst_n low at beat 5 of a transfer -> all outputs zero immediately; after release with req=4'b0110, grant goes to requester 1.
REQ-035 BURST_LEN=1, req=4'b0101 held -> alternating single-beat grants 0,2,0,2 with GAP between each.
